packet_arbiter_mux: RTL and testbench

//  N-channel request arbiter/router between client-side packet ports (inst, data, prefetch, ...)
//  and one memory-side packet port. Generalises the fixed inst/data pairing to NUM_PORTS channels.

---
 rtl/packet_arbiter_mux.sv | 168 ++++++++++++++++
 tb/tb_packet_arbiter_mux.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter_mux.sv
// Round-robin request arbiter from NUM_PORTS client packet ports onto one memory
// port. In-order response routing uses a FIFO of granted port IDs.
module packet_arbiter_mux #(
  parameter int unsigned NUM_PORTS         = 2,
  parameter int unsigned PACKET_WIDTH      = 32,
  parameter int unsigned VALID_POS         = PACKET_WIDTH - 1,
  parameter int unsigned OUTSTANDING_DEPTH = 4
) (
  input  logic                              clk_in,
  input  logic                              reset_n_in,
  input  logic [NUM_PORTS*PACKET_WIDTH-1:0] req_packet_flatted_in,
  output logic [NUM_PORTS-1:0]              req_packet_ack_flatted_out,
  output logic [NUM_PORTS*PACKET_WIDTH-1:0] resp_packet_flatted_out,
  input  logic [NUM_PORTS-1:0]              resp_packet_ack_flatted_in,
  output logic [PACKET_WIDTH-1:0]           to_mem_packet_out,
  input  logic                              to_mem_packet_ack_in,
  input  logic [PACKET_WIDTH-1:0]           from_mem_packet_in,
  output logic                              from_mem_packet_ack_out,
  output logic                              error_out
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTR_W  = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(OUTSTANDING_DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state_q;
  state_t                    state_nxt;
  logic [PORT_W-1:0]         last_grant_q;
  logic [PACKET_WIDTH-1:0]   req_slice [NUM_PORTS];
  logic [PACKET_WIDTH-1:0]   resp_q    [NUM_PORTS];
  logic [NUM_PORTS-1:0]      eligible_c;
  logic                      grant_valid_c;
  logic [PORT_W-1:0]         grant_idx_c;
  logic                      do_grant_c;
  logic                      do_release_c;

  logic [PORT_W-1:0]         fifo_mem [OUTSTANDING_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic                      fifo_full_c;
  logic                      fifo_empty_c;
  logic [PORT_W-1:0]         head_port_c;
  logic                      mem_accept_c;
  logic                      pop_c;

  // Per-port unpack of request/response buses and eligibility
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign req_slice[p] = req_packet_flatted_in[p*PACKET_WIDTH +: PACKET_WIDTH];
    assign eligible_c[p] = req_slice[p][VALID_POS] & ~req_packet_ack_flatted_out[p];
    assign resp_packet_flatted_out[p*PACKET_WIDTH +: PACKET_WIDTH] = resp_q[p];

    // Response slot: cleared by client ack, loaded when its ID is popped
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        resp_q[p] <= '0;
      end else begin
        if (resp_packet_ack_flatted_in[p]) resp_q[p] <= '0;
        if (pop_c && (head_port_c == PORT_W'(p))) resp_q[p] <= from_mem_packet_in;
      end
    end
  end

  assign fifo_full_c  = (count_q == CNT_W'(OUTSTANDING_DEPTH));
  assign fifo_empty_c = (count_q == '0);
  assign head_port_c  = fifo_mem[rd_ptr_q];

  // Round-robin winner: first eligible port after last_grant, wrapping
  always_comb begin
    grant_valid_c = 1'b0;
    grant_idx_c   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      if (!grant_valid_c && eligible_c[PORT_W'((32'(last_grant_q) + k) % NUM_PORTS)]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = PORT_W'((32'(last_grant_q) + k) % NUM_PORTS);
      end
    end
  end

  // Memory response acceptance; an empty FIFO still acks but flags an error
  assign mem_accept_c = from_mem_packet_in[VALID_POS] & ~from_mem_packet_ack_out &
                        (fifo_empty_c | ~resp_q[head_port_c][VALID_POS]);
  assign pop_c        = mem_accept_c & ~fifo_empty_c;

  // Request FSM state register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= IDLE;
    else             state_q <= state_nxt;
  end

  // Request FSM next state: grant in IDLE, hold until memory accepts in SEND
  always_comb begin
    state_nxt    = state_q;
    do_grant_c   = 1'b0;
    do_release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid_c && !fifo_full_c) begin
          do_grant_c = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (to_mem_packet_ack_in) begin
          do_release_c = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request-side outputs and round-robin pointer
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      req_packet_ack_flatted_out <= '0;
      to_mem_packet_out          <= '0;
      last_grant_q               <= PORT_W'(NUM_PORTS - 1);
    end else begin
      req_packet_ack_flatted_out <= '0;
      if (do_grant_c) begin
        req_packet_ack_flatted_out[grant_idx_c] <= 1'b1;
        to_mem_packet_out                       <= req_slice[grant_idx_c];
        last_grant_q                            <= grant_idx_c;
      end else if (do_release_c) begin
        to_mem_packet_out <= '0;
      end
    end
  end

  // Port-ID FIFO storage
  always_ff @(posedge clk_in) begin
    if (do_grant_c) fifo_mem[wr_ptr_q] <= grant_idx_c;
  end

  // Port-ID FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_grant_c)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTSTANDING_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop_c)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTANDING_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({do_grant_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Memory-side ack pulse and sticky orphan-response flag
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      from_mem_packet_ack_out <= 1'b0;
      error_out               <= 1'b0;
    end else begin
      from_mem_packet_ack_out <= mem_accept_c;
      if (mem_accept_c && fifo_empty_c) error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_arbiter_mux.sv
// Bench for packet_arbiter_mux: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_packet_arbiter_mux;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned VP = 15;
  localparam int unsigned D  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N*W-1:0]   req = '0;
  logic [N-1:0]     req_ack;
  logic [N*W-1:0]   resp;
  logic [N-1:0]     resp_ack = '0;
  logic [W-1:0]     to_mem;
  logic             to_mem_ack = 1'b0;
  logic [W-1:0]     from_mem = '0;
  logic             from_ack;
  logic             err;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  packet_arbiter_mux #(
    .NUM_PORTS(N), .PACKET_WIDTH(W), .VALID_POS(VP), .OUTSTANDING_DEPTH(D)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .req_packet_flatted_in(req),
    .req_packet_ack_flatted_out(req_ack),
    .resp_packet_flatted_out(resp),
    .resp_packet_ack_flatted_in(resp_ack),
    .to_mem_packet_out(to_mem),
    .to_mem_packet_ack_in(to_mem_ack),
    .from_mem_packet_in(from_mem),
    .from_mem_packet_ack_out(from_ack),
    .error_out(err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_req_ack;
  logic [W-1:0] m_to;
  logic [W-1:0] m_resp [N];
  logic         m_from_ack;
  logic         m_err;
  bit           m_busy;
  int           m_last;
  int           m_q[$];

  task automatic model_reset();
    m_req_ack = '0; m_to = '0; m_from_ack = 1'b0; m_err = 1'b0;
    m_busy = 1'b0; m_last = N - 1; m_q.delete();
    for (int p = 0; p < N; p++) m_resp[p] = '0;
  endtask

  function automatic logic [N*W-1:0] m_resp_flat();
    logic [N*W-1:0] f;
    for (int p = 0; p < N; p++) f[p*W +: W] = m_resp[p];
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration by rule, ID ordering as a queue
  initial begin
    model_reset();
    forever begin : upd
      logic [N-1:0] n_ack;
      logic [W-1:0] n_to;
      logic [W-1:0] n_resp [N];
      logic         n_from;
      int           grant;
      bit           pop;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        n_ack = '0; n_to = m_to; n_from = 1'b0; grant = -1; pop = 1'b0;
        if (!m_busy) begin
          if (m_q.size() < D)
            for (int k = 1; k <= N; k++) begin
              int p;
              p = (m_last + k) % N;
              if (grant < 0 && req[p*W + VP] && !m_req_ack[p]) grant = p;
            end
          if (grant >= 0) begin
            n_to = req[grant*W +: W]; n_ack[grant] = 1'b1; m_busy = 1'b1;
          end
        end else if (to_mem_ack) begin
          n_to = '0; m_busy = 1'b0;
        end
        for (int p = 0; p < N; p++) n_resp[p] = resp_ack[p] ? '0 : m_resp[p];
        if (from_mem[VP] && !m_from_ack) begin
          if (m_q.size() == 0) begin
            n_from = 1'b1; m_err = 1'b1;
          end else if (!m_resp[m_q[0]][VP]) begin
            n_resp[m_q[0]] = from_mem; n_from = 1'b1; pop = 1'b1;
          end
        end
        if (pop) void'(m_q.pop_front());
        if (grant >= 0) begin m_q.push_back(grant); m_last = grant; end
        m_req_ack = n_ack; m_to = n_to; m_from_ack = n_from;
        for (int p = 0; p < N; p++) m_resp[p] = n_resp[p];
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_req_ack",  64'(req_ack),  64'(m_req_ack));
      chk("cyc_to_mem",   64'(to_mem),   64'(m_to));
      chk("cyc_resp",     64'(resp),     64'(m_resp_flat()));
      chk("cyc_from_ack", 64'(from_ack), 64'(m_from_ack));
      chk("cyc_error",    64'(err),      64'(m_err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] valid_pkt();
    return W'($urandom) | (W'(1) << VP);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; resp_ack = '0; to_mem_ack = 1'b0; from_mem = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives clients and memory from model state with percentage knobs
  task automatic service(input int p_req, input int p_tack, input int p_from,
                         input int p_rack, input logic [N-1:0] active);
    for (int p = 0; p < N; p++) begin
      if (m_req_ack[p] || !req[p*W + VP]) begin
        if (active[p] && ($urandom_range(99) < p_req)) req[p*W +: W] = valid_pkt();
        else                                           req[p*W +: W] = '0;
      end
      resp_ack[p] = ($urandom_range(99) < p_rack);
    end
    to_mem_ack = ($urandom_range(99) < p_tack);
    if (m_q.size() > 0 && ($urandom_range(99) < p_from)) from_mem = valid_pkt();
    else from_mem = W'($urandom) & ~(W'(1) << VP);
  endtask

  task automatic wait_grant(input logic [N-1:0] active, output logic [N-1:0] got);
    got = '0;
    for (int i = 0; i < 20 && got == '0; i++) begin
      @(negedge clk);
      got = req_ack;
      service(100, 100, 100, 100, active);
    end
  endtask

  initial begin
    logic [N-1:0] got;
    logic [N-1:0] mask;
    int           pulses;

    #1 rst_n = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    chk("reset_to_mem",   64'(to_mem),   64'h0);
    chk("reset_req_ack",  64'(req_ack),  64'h0);
    chk("reset_resp",     64'(resp),     64'h0);
    chk("reset_from_ack", 64'(from_ack), 64'h0);
    chk("reset_error",    64'(err),      64'h0);

    // Single read on port 0
    req[0 +: W] = 16'h8040;
    @(negedge clk);
    chk("t1_req_ack", 64'(req_ack), 64'h1);
    chk("t1_to_mem",  64'(to_mem),  64'h8040);
    req = '0; to_mem_ack = 1'b1;
    @(negedge clk);
    chk("t1_to_mem_clr", 64'(to_mem), 64'h0);
    to_mem_ack = 1'b0; from_mem = 16'h8004;
    @(negedge clk);
    chk("t1_from_ack", 64'(from_ack), 64'h1);
    chk("t1_resp0",    64'(resp),     64'h8004);
    from_mem = '0; resp_ack = 3'b001;
    @(negedge clk);
    chk("t1_resp_clr",     64'(resp),     64'h0);
    chk("t1_from_ack_end", 64'(from_ack), 64'h0);
    resp_ack = '0;

    // Orphan response sets the sticky error
    do_reset();
    from_mem = 16'h8123;
    @(negedge clk);
    chk("t5_from_ack", 64'(from_ack), 64'h1);
    chk("t5_error",    64'(err),      64'h1);
    chk("t5_resp",     64'(resp),     64'h0);
    from_mem = '0;
    repeat (3) @(negedge clk);
    chk("t5_error_sticky", 64'(err),      64'h1);
    chk("t5_from_ack_end", 64'(from_ack), 64'h0);

    // Two ports always requesting alternate grants
    do_reset();
    service(100, 100, 100, 100, 3'b011);
    for (int i = 0; i < 6; i++) begin
      wait_grant(3'b011, got);
      chk($sformatf("t2_grant%0d", i), 64'(got), (i % 2 == 0) ? 64'h1 : 64'h2);
    end

    // FIFO depth limit: third request waits for the first response
    do_reset();
    req = {16'h8C02, 16'h8C01, 16'h8C00};
    to_mem_ack = 1'b1;
    mask = '0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mask |= req_ack;
      if (req_ack != '0) pulses++;
      for (int p = 0; p < N; p++) if (m_req_ack[p]) req[p*W +: W] = '0;
    end
    chk("t3_grant_mask",   64'(mask),    64'h3);
    chk("t3_grant_pulses", 64'(pulses),  64'h2);
    chk("t3_to_mem_idle",  64'(to_mem),  64'h0);
    from_mem = 16'h8AAA;
    @(negedge clk);
    chk("t3_from_ack", 64'(from_ack), 64'h1);
    chk("t3_resp0",    64'(resp),     64'h8AAA);
    chk("t3_no_grant", 64'(req_ack),  64'h0);
    from_mem = '0;
    @(negedge clk);
    chk("t3_grant2", 64'(req_ack), 64'h4);
    chk("t3_to_mem", 64'(to_mem),  64'h8C02);

    // Asynchronous reset while a request is in flight
    do_reset();
    req[W +: W] = 16'h8011;
    @(negedge clk);
    chk("t6_to_mem_send", 64'(to_mem), 64'h8011);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_to_mem",   64'(to_mem),   64'h0);
    chk("t6_rst_req_ack",  64'(req_ack),  64'h0);
    chk("t6_rst_resp",     64'(resp),     64'h0);
    chk("t6_rst_from_ack", 64'(from_ack), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    req[0 +: W] = 16'h8100;
    req[W +: W] = 16'h8111;
    @(negedge clk);
    chk("t6_first_grant", 64'(req_ack), 64'h1);
    chk("t6_first_data",  64'(to_mem),  64'h8100);

    // Randomized traffic with varying back-pressure
    do_reset();
    for (int phase = 0; phase < 4; phase++) begin
      int p_tack, p_rack;
      p_tack = (phase == 1) ? 20 : 60;
      p_rack = (phase == 2) ? 10 : 50;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        service(60, p_tack, 50, p_rack, 3'b111);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
